ad9958_write_sequencer: RTL and testbench
=========================================

AD9958_WRITE_SEQUENCER -- requirements
Module: ad9958_write_sequencer

Interface
REQ-001 Parameter: IO_UPDATE_CYCLES, default 4, width in clock cycles of the io_update pulse.
REQ-002 Parameter: BUSY_TIMEOUT, default 15, cycles allowed from spi_trigger to spi_busy rising.
REQ-003 Port: clock  in  1  single system clock; all logic on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: req_valid  in  1  write request present.
REQ-006 Port: req_ready  out  1  sequencer accepts a request this cycle.
REQ-007 Port: req_addr  in  5  AD9958 register address.
REQ-008 Port: req_data  in  32  register data, right-aligned.
REQ-009 Port: req_chan  in  2  channel enables {ch1,ch0}; ignored for global registers.
REQ-010 Port: req_update  in  1  pulse io_update after the write.
REQ-011 Port: done  out  1  one-cycle pulse; request completed.
REQ-012 Port: err  out  1  one-cycle pulse; request rejected or aborted.
REQ-013 Port: spi_trigger  out  1  one-cycle start pulse to the 4-bit SPI engine.
REQ-014 Port: spi_busy  in  1  SPI engine busy.
REQ-015 Port: spi_packs  out  5  nibble count for the transfer.
REQ-016 Port: spi_data  out  64  nibble-packed transfer word; nibble k at bits [4k+3:4k], nibble 0 sent first.
REQ-017 Port: io_update  out  1  AD9958 IO_UPDATE strobe.
REQ-018 Port: cur_chan  out  2  channel enables last written to CSR.

Function
REQ-019 Handshake: a request SHALL transfer on the cycle req_valid and req_ready are both 1; req_ready is 1 only in IDLE.
REQ-020 Request fields SHALL be captured at acceptance; later input changes have no effect.
REQ-021 Address 0x00-0x02 SHALL be global; 0x03-0x18 per-channel; 0x19-0x1F SHALL produce err one cycle after acceptance, with no SPI transfer.
REQ-022 Data byte count by address: 0x00=1, 0x01=3, 0x02=2, 0x03=3, 0x04=4, 0x05=2, 0x06=3, 0x07=2, 0x08-0x18=4.
REQ-023 Transfer byte stream SHALL be instruction {1'b0,2'b00,addr}, then the low N data bytes MSB-first; each byte high nibble first; spi_packs = 2+2N.
REQ-024 A per-channel write SHALL first issue a CSR write (addr 0x00, data {req_chan,3'b000,2'b11,1'b0}) when csr_known=0 or req_chan differs from cur_chan.
REQ-025 A direct write to 0x00 SHALL update cur_chan from req_data[7:6] and set csr_known.
REQ-026 States: IDLE, CSR_LOAD, CSR_WAIT, REG_LOAD, REG_WAIT, UPDATE, with the following transitions.
REQ-027 Transitions: IDLE->CSR_LOAD or REG_LOAD on accept; *_LOAD asserts spi_trigger for one cycle then ->*_WAIT; *_WAIT waits for spi_busy=1, then spi_busy=0; CSR_WAIT->REG_LOAD; REG_WAIT->UPDATE if req_update else ->IDLE with done.
REQ-028 UPDATE SHALL drive io_update high for exactly IO_UPDATE_CYCLES cycles, then return to IDLE with done.
REQ-029 spi_data and spi_packs SHALL be stable from the trigger cycle until spi_busy falls.
REQ-030 If spi_busy is not seen within BUSY_TIMEOUT cycles after trigger, the sequencer SHALL pulse err, clear csr_known, and return to IDLE.
REQ-031 spi_trigger SHALL never assert while spi_busy=1.

Reset
REQ-032 On reset: state=IDLE, req_ready=1 on the next cycle, done=err=spi_trigger=io_update=0, spi_data=0, spi_packs=0, cur_chan=0, csr_known=0.
REQ-033 Reset during a transfer SHALL abort immediately; the first request after reset SHALL re-issue CSR.

Structure
REQ-034 Package ad9958_pkg SHALL hold the state enum, register address constants, CSR mode bits and the address-to-byte-count function.
REQ-035 One sub-module ad9958_nibble_packer (combinational: addr, data, N -> spi_data, spi_packs) SHALL be instantiated twice or muxed.

Verification
REQ-036 Reset, then write 0x04 with data 0x12345678 and chan 01 -> CSR transfer first (spi_data 0x6400, packs 4), then spi_data 0x0087654321 40 (spi_data=0x0000008765432140), packs 10, then done.
REQ-037 Repeat the same channel write to 0x05 with data 0xABCD -> no CSR, spi_data 0xDCBA50, packs 6.
REQ-038 Write 0x01 with data 0xA0B0C0, req_update=1 -> no CSR; io_update high exactly 4 cycles, then done.
REQ-039 Write 0x1A -> err pulse, spi_trigger never asserts, req_ready back in IDLE.
REQ-040 spi_busy held 0 after trigger -> err on cycle 16 after trigger, csr_known cleared, next channel write re-issues CSR.
REQ-041 Assert reset mid-REG_WAIT -> all outputs at reset values next cycle; next request re-issues CSR with cur_chan restarted.

Source files
------------

// File: rtl/ad9958_pkg.sv
// rtl/ad9958_pkg.sv - shared types, register map and sizing helpers for the AD9958 write sequencer
package ad9958_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CSR_LOAD = 3'd1,
        ST_CSR_WAIT = 3'd2,
        ST_REG_LOAD = 3'd3,
        ST_REG_WAIT = 3'd4,
        ST_UPDATE   = 3'd5
    } seq_state_t;

    localparam logic [4:0] ADDR_CSR  = 5'h00;
    localparam logic [4:0] ADDR_FR1  = 5'h01;
    localparam logic [4:0] ADDR_FR2  = 5'h02;
    localparam logic [4:0] ADDR_CFR  = 5'h03;
    localparam logic [4:0] ADDR_CFTW = 5'h04;
    localparam logic [4:0] ADDR_CPOW = 5'h05;
    localparam logic [4:0] ADDR_ACR  = 5'h06;
    localparam logic [4:0] ADDR_LSRR = 5'h07;
    localparam logic [4:0] ADDR_RDW  = 5'h08;
    localparam logic [4:0] ADDR_LAST = 5'h18;

    // CSR low bits: 4-bit serial I/O mode, MSB-first
    localparam logic [5:0] CSR_MODE_BITS = 6'b000_11_0;

    // Zero marks an address outside the register map
    function automatic logic [2:0] addr_byte_count(input logic [4:0] addr);
        logic [2:0] n;
        case (addr)
            ADDR_CSR:  n = 3'd1;
            ADDR_FR1:  n = 3'd3;
            ADDR_FR2:  n = 3'd2;
            ADDR_CFR:  n = 3'd3;
            ADDR_CFTW: n = 3'd4;
            ADDR_CPOW: n = 3'd2;
            ADDR_ACR:  n = 3'd3;
            ADDR_LSRR: n = 3'd2;
            default:   n = (addr >= ADDR_RDW && addr <= ADDR_LAST) ? 3'd4 : 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic is_global_addr(input logic [4:0] addr);
        return addr <= ADDR_FR2;
    endfunction

    function automatic logic [31:0] csr_word(input logic [1:0] chan);
        return {24'h000000, chan, CSR_MODE_BITS};
    endfunction

endpackage

// File: rtl/ad9958_nibble_packer.sv
// rtl/ad9958_nibble_packer.sv - packs instruction byte plus N data bytes into the 4-bit SPI nibble word
module ad9958_nibble_packer
    import ad9958_pkg::*;
(
    input  logic [4:0]  addr,
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    output logic [63:0] spi_data,
    output logic [4:0]  spi_packs
);

    logic [5:0]  shift_amt;
    logic [31:0] aligned;

    always_comb begin
        // Left-justify the N live bytes so unused upper bytes fall off and tail bytes read as zero
        shift_amt = {3'd4 - nbytes, 3'b000};
        aligned   = data << shift_amt;

        spi_data      = '0;
        spi_data[3:0] = {3'b000, addr[4]};
        spi_data[7:4] = addr[3:0];
        for (int i = 0; i < 4; i++) begin
            spi_data[8*i+8  +: 4] = aligned[31-8*i -: 4];
            spi_data[8*i+12 +: 4] = aligned[27-8*i -: 4];
        end
        spi_packs = 5'd2 + {1'b0, nbytes, 1'b0};
    end

endmodule

// File: rtl/ad9958_write_sequencer.sv
// rtl/ad9958_write_sequencer.sv - turns register write requests into CSR/register SPI transfers and IO_UPDATE pulses
module ad9958_write_sequencer
    import ad9958_pkg::*;
#(
    parameter int IO_UPDATE_CYCLES = 4,
    parameter int BUSY_TIMEOUT     = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_chan,
    input  logic        req_update,
    output logic        done,
    output logic        err,
    output logic        spi_trigger,
    input  logic        spi_busy,
    output logic [4:0]  spi_packs,
    output logic [63:0] spi_data,
    output logic        io_update,
    output logic [1:0]  cur_chan
);

    localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int UPD_W = (IO_UPDATE_CYCLES > 1) ? $clog2(IO_UPDATE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [UPD_W-1:0] UPD_LAST = UPD_W'(IO_UPDATE_CYCLES - 1);

    seq_state_t        state, state_next;
    logic [4:0]        cap_addr, cap_addr_next;
    logic [31:0]       cap_data, cap_data_next;
    logic [1:0]        cap_chan, cap_chan_next;
    logic              cap_update, cap_update_next;
    logic [63:0]       spi_data_r, spi_data_next;
    logic [4:0]        spi_packs_r, spi_packs_next;
    logic [1:0]        cur_chan_r, cur_chan_next;
    logic              csr_known, csr_known_next;
    logic              busy_seen, busy_seen_next;
    logic [TMR_W-1:0]  tmr, tmr_next;
    logic [UPD_W-1:0]  upd_cnt, upd_next;
    logic              done_r, done_next;
    logic              err_r, err_next;

    logic [4:0]        pk_addr;
    logic [31:0]       pk_data;
    logic [63:0]       reg_pk_data, csr_pk_data;
    logic [4:0]        reg_pk_packs, csr_pk_packs;

    // In IDLE the register word is packed straight from the request so it can be loaded on accept
    assign pk_addr = (state == ST_IDLE) ? req_addr : cap_addr;
    assign pk_data = (state == ST_IDLE) ? req_data : cap_data;

    ad9958_nibble_packer u_reg_packer (
        .addr      (pk_addr),
        .data      (pk_data),
        .nbytes    (addr_byte_count(pk_addr)),
        .spi_data  (reg_pk_data),
        .spi_packs (reg_pk_packs)
    );

    ad9958_nibble_packer u_csr_packer (
        .addr      (ADDR_CSR),
        .data      (csr_word(req_chan)),
        .nbytes    (3'd1),
        .spi_data  (csr_pk_data),
        .spi_packs (csr_pk_packs)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cap_addr    <= '0;
            cap_data    <= '0;
            cap_chan    <= '0;
            cap_update  <= 1'b0;
            spi_data_r  <= '0;
            spi_packs_r <= '0;
            cur_chan_r  <= '0;
            csr_known   <= 1'b0;
            busy_seen   <= 1'b0;
            tmr         <= '0;
            upd_cnt     <= '0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state       <= state_next;
            cap_addr    <= cap_addr_next;
            cap_data    <= cap_data_next;
            cap_chan    <= cap_chan_next;
            cap_update  <= cap_update_next;
            spi_data_r  <= spi_data_next;
            spi_packs_r <= spi_packs_next;
            cur_chan_r  <= cur_chan_next;
            csr_known   <= csr_known_next;
            busy_seen   <= busy_seen_next;
            tmr         <= tmr_next;
            upd_cnt     <= upd_next;
            done_r      <= done_next;
            err_r       <= err_next;
        end
    end

    always_comb begin
        state_next      = state;
        cap_addr_next   = cap_addr;
        cap_data_next   = cap_data;
        cap_chan_next   = cap_chan;
        cap_update_next = cap_update;
        spi_data_next   = spi_data_r;
        spi_packs_next  = spi_packs_r;
        cur_chan_next   = cur_chan_r;
        csr_known_next  = csr_known;
        busy_seen_next  = busy_seen;
        tmr_next        = tmr;
        upd_next        = upd_cnt;
        done_next       = 1'b0;
        err_next        = 1'b0;
        req_ready       = 1'b0;
        spi_trigger     = 1'b0;
        io_update       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cap_addr_next   = req_addr;
                    cap_data_next   = req_data;
                    cap_chan_next   = req_chan;
                    cap_update_next = req_update;
                    if (addr_byte_count(req_addr) == 3'd0) begin
                        err_next = 1'b1;
                    end else if (!is_global_addr(req_addr) &&
                                 (!csr_known || req_chan != cur_chan_r)) begin
                        state_next     = ST_CSR_LOAD;
                        spi_data_next  = csr_pk_data;
                        spi_packs_next = csr_pk_packs;
                    end else begin
                        state_next     = ST_REG_LOAD;
                        spi_data_next  = reg_pk_data;
                        spi_packs_next = reg_pk_packs;
                    end
                end
            end

            // Hold off the trigger while the engine still reports busy
            ST_CSR_LOAD, ST_REG_LOAD: begin
                if (!spi_busy) begin
                    spi_trigger    = 1'b1;
                    state_next     = (state == ST_CSR_LOAD) ? ST_CSR_WAIT : ST_REG_WAIT;
                    busy_seen_next = 1'b0;
                    tmr_next       = '0;
                end
            end

            ST_CSR_WAIT, ST_REG_WAIT: begin
                if (!busy_seen) begin
                    if (spi_busy) begin
                        busy_seen_next = 1'b1;
                    end else if (tmr == TMR_LAST) begin
                        // Device CSR contents are unknown after an aborted transfer
                        err_next       = 1'b1;
                        csr_known_next = 1'b0;
                        state_next     = ST_IDLE;
                    end else begin
                        tmr_next = tmr + 1'b1;
                    end
                end else if (!spi_busy) begin
                    if (state == ST_CSR_WAIT) begin
                        cur_chan_next  = cap_chan;
                        csr_known_next = 1'b1;
                        state_next     = ST_REG_LOAD;
                        spi_data_next  = reg_pk_data;
                        spi_packs_next = reg_pk_packs;
                    end else begin
                        if (cap_addr == ADDR_CSR) begin
                            cur_chan_next  = cap_data[7:6];
                            csr_known_next = 1'b1;
                        end
                        if (cap_update) begin
                            state_next = ST_UPDATE;
                            upd_next   = '0;
                        end else begin
                            done_next  = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
            end

            ST_UPDATE: begin
                io_update = 1'b1;
                if (upd_cnt == UPD_LAST) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    upd_next = upd_cnt + 1'b1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign done      = done_r;
    assign err       = err_r;
    assign spi_data  = spi_data_r;
    assign spi_packs = spi_packs_r;
    assign cur_chan  = cur_chan_r;

endmodule

// File: tb/tb_ad9958_write_sequencer.sv
// tb/tb_ad9958_write_sequencer.sv - randomized self-checking bench for ad9958_write_sequencer
module tb_ad9958_write_sequencer;

    localparam int IO_UPD  = 4;
    localparam int BUSY_TO = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_chan;
    logic        req_update;
    logic        done;
    logic        err;
    logic        spi_trigger;
    logic        spi_busy;
    logic [4:0]  spi_packs;
    logic [63:0] spi_data;
    logic        io_update;
    logic [1:0]  cur_chan;

    ad9958_write_sequencer #(
        .IO_UPDATE_CYCLES (IO_UPD),
        .BUSY_TIMEOUT     (BUSY_TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_chan    (req_chan),
        .req_update  (req_update),
        .done        (done),
        .err         (err),
        .spi_trigger (spi_trigger),
        .spi_busy    (spi_busy),
        .spi_packs   (spi_packs),
        .spi_data    (spi_data),
        .io_update   (io_update),
        .cur_chan    (cur_chan)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  packs;
        int          cyc;
    } xfer_t;

    xfer_t      obs[$];
    xfer_t      exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         eng_dead = 1'b0;
    bit         eng_long = 1'b0;
    bit         eng_abort = 1'b0;
    bit         m_known = 1'b0;
    logic [1:0] m_chan = 2'b00;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int bytes_of(input logic [4:0] a);
        case (a)
            5'h00: return 1;
            5'h01: return 3;
            5'h02: return 2;
            5'h03: return 3;
            5'h04: return 4;
            5'h05: return 2;
            5'h06: return 3;
            5'h07: return 2;
            default: return (a <= 5'h18) ? 4 : 0;
        endcase
    endfunction

    // Byte stream -> nibble stream -> word, nibble k at bits 4k
    function automatic xfer_t mk_xfer(input logic [4:0] a, input logic [31:0] d, input int n);
        int          nib[$];
        logic [7:0]  b;
        logic [31:0] sh;
        xfer_t       x;
        b = {3'b000, a};
        nib.push_back(int'(b[7:4]));
        nib.push_back(int'(b[3:0]));
        for (int j = n - 1; j >= 0; j--) begin
            sh = d >> (8 * j);
            b  = sh[7:0];
            nib.push_back(int'(b[7:4]));
            nib.push_back(int'(b[3:0]));
        end
        x.data = '0;
        foreach (nib[k]) x.data = x.data | (64'(nib[k]) << (4 * k));
        x.packs = 5'(2 + 2 * n);
        x.cyc   = 0;
        return x;
    endfunction

    // SPI engine responder
    initial begin
        xfer_t x;
        int    d;
        int    len;
        int    k;
        spi_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (spi_trigger === 1'b1 && reset === 1'b0) begin
                x.data  = spi_data;
                x.packs = spi_packs;
                x.cyc   = cyc;
                obs.push_back(x);
                check("trig_while_busy", 64'(spi_busy), 64'(0));
                if (!eng_dead) begin
                    d   = $urandom_range(1, 6);
                    len = eng_long ? 5000 : $urandom_range(1, 6);
                    repeat (d) @(negedge clock);
                    spi_busy = 1'b1;
                    k = 0;
                    while (k < len && !eng_abort) begin
                        @(negedge clock);
                        k++;
                    end
                    if (!eng_abort) begin
                        check("stable_data", spi_data, x.data);
                        check("stable_packs", 64'(spi_packs), 64'(x.packs));
                    end
                    spi_busy = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [4:0] a, input logic [31:0] d, input logic [1:0] ch, input logic up);
        req_valid  = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_chan   = ch;
        req_update = up;
        check("ready_idle", 64'(req_ready), 64'(1));
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        req_addr   = 5'($urandom);
        req_data   = $urandom;
        req_chan   = 2'($urandom);
        req_update = 1'($urandom);
    endtask

    task automatic run_req(input logic [4:0] a, input logic [31:0] d, input logic [1:0] ch,
                           input logic up, input bit dead);
        int         n;
        bit         csr;
        bit         got;
        int         lat_k;
        int         upd_seen;
        int         resp_cyc;
        logic [1:0] exp_resp;
        int         exp_upd;
        obs.delete();
        exp_q.delete();
        n   = bytes_of(a);
        csr = (n != 0) && (a >= 5'h03) && (!m_known || ch != m_chan);
        if (csr) exp_q.push_back(mk_xfer(5'h00, {24'h0, ch, 6'b000110}, 1));
        if (n != 0) exp_q.push_back(mk_xfer(a, d, n));
        if (n == 0) begin
            exp_resp = 2'b01;
            exp_upd  = 0;
        end else if (dead) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
            exp_resp = 2'b01;
            exp_upd  = 0;
            m_known  = 1'b0;
        end else begin
            exp_resp = 2'b10;
            exp_upd  = up ? IO_UPD : 0;
            if (csr) begin
                m_chan  = ch;
                m_known = 1'b1;
            end
            if (a == 5'h00) begin
                m_chan  = d[7:6];
                m_known = 1'b1;
            end
        end
        eng_dead = dead;
        send(a, d, ch, up);
        got = 1'b0;
        lat_k = 0;
        upd_seen = 0;
        resp_cyc = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clock);
            if (io_update === 1'b1) upd_seen++;
            if (done === 1'b1 || err === 1'b1) begin
                got      = 1'b1;
                lat_k    = k;
                resp_cyc = cyc;
                break;
            end
        end
        check("resp_seen", 64'(got), 64'(1));
        check("resp_kind", 64'({done, err}), 64'(exp_resp));
        check("ready_after", 64'(req_ready), 64'(1));
        check("io_update_len", 64'(upd_seen), 64'(exp_upd));
        check("xfer_count", 64'(obs.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            check("xfer_data", obs[i].data, exp_q[i].data);
            check("xfer_packs", 64'(obs[i].packs), 64'(exp_q[i].packs));
        end
        if (n == 0) check("err_latency", 64'(lat_k), 64'(1));
        if (n != 0 && dead && obs.size() > 0)
            check("timeout_latency", 64'(resp_cyc - obs[0].cyc), 64'(BUSY_TO + 1));
        check("cur_chan", 64'(cur_chan), 64'(m_chan));
        @(negedge clock);
        check("pulse_width", 64'({done, err}), 64'(0));
        eng_dead = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'(1));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_trig"}, 64'(spi_trigger), 64'(0));
        check({tag, "_ioupd"}, 64'(io_update), 64'(0));
        check({tag, "_data"}, spi_data, 64'(0));
        check({tag, "_packs"}, 64'(spi_packs), 64'(0));
        check({tag, "_chan"}, 64'(cur_chan), 64'(0));
    endtask

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        bit          reached;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_chan   = '0;
        req_update = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_reset_outputs("rst");

        // Channel write from cold: CSR then register
        run_req(5'h04, 32'h12345678, 2'b01, 1'b0, 1'b0);
        check("d36_csr_word", (obs.size() > 0) ? obs[0].data : '1, 64'h6400);
        check("d36_reg_word", (obs.size() > 1) ? obs[1].data : '1, 64'h0000008765432140);
        check("d36_reg_packs", 64'((obs.size() > 1) ? obs[1].packs : 5'h1f), 64'd10);

        // Same channel: no CSR
        run_req(5'h05, 32'h0000ABCD, 2'b01, 1'b0, 1'b0);
        check("d37_word", (obs.size() == 1) ? obs[0].data : '1, 64'hDCBA50);

        // Global register with IO_UPDATE
        run_req(5'h01, 32'h00A0B0C0, 2'b10, 1'b1, 1'b0);

        // Out-of-map address
        run_req(5'h1A, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0);

        // Engine never goes busy, then CSR must be re-issued
        run_req(5'h04, 32'h0BADF00D, 2'b01, 1'b0, 1'b1);
        run_req(5'h04, 32'h01020304, 2'b01, 1'b0, 1'b0);
        check("d40_csr_reissue", 64'(obs.size()), 64'(2));

        // Reset in the middle of a register transfer
        obs.delete();
        eng_long = 1'b1;
        send(5'h01, 32'h00112233, 2'b00, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (obs.size() == 1 && spi_busy === 1'b1) begin
                reached = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("d41_in_wait", 64'(reached), 64'(1));
        @(negedge clock);
        reset     = 1'b1;
        eng_abort = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_outputs("midrst");
        for (int i = 0; i < 10 && spi_busy === 1'b1; i++) @(negedge clock);
        eng_abort = 1'b0;
        eng_long  = 1'b0;
        m_known   = 1'b0;
        m_chan    = 2'b00;
        @(negedge clock);
        run_req(5'h03, 32'h00445566, 2'b00, 1'b0, 1'b0);
        check("d41_csr_after_reset", 64'(obs.size()), 64'(2));

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) ra = 5'($urandom_range(25, 31));
            else ra = 5'($urandom_range(0, 24));
            rd = $urandom;
            run_req(ra, rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                    $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got no_finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
